// File: rtl/mux_4_1_rr_arbiter.sv
// Four-requester round-robin arbiter in front of a 4:1 data mux.
// The winning requester's word is registered onto a single valid/ready
// output. A requester may keep the grant for up to MAX_BURST consecutive
// transfers while others wait, after which the search rotates.
module mux_4_1_rr_arbiter #(
  parameter int W         = 4,
  parameter int MAX_BURST = 2   // legal range 1..15; 1 gives pure round-robin
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  localparam int             RW      = $clog2(MAX_BURST + 1);
  localparam logic [RW-1:0]  MAX_RUN = RW'(MAX_BURST);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic [1:0]   r_out_sel;
  logic [1:0]   r_last;
  logic [RW-1:0] r_run;

  logic         w_load;
  logic         w_xfer;
  logic         w_hold;
  logic [1:0]   w_rot;
  logic [1:0]   w_grant;
  logic [W-1:0] w_sel_data;
  logic [RW-1:0] w_run_next;

  // The output register may take a new word when it is empty or being drained.
  assign w_load = !r_out_valid || out_ready;
  assign w_xfer = w_load && (in_valid != 4'b0000);

  // Stay with the last grantee while it is valid and under its burst limit.
  // run == 0 only after reset, meaning nobody has been granted yet, so the
  // first search starts at requester 0 instead of holding on requester 3.
  assign w_hold = in_valid[r_last] && (r_run != '0) && (r_run < MAX_RUN);

  // Rotating search last+1, last+2, last+3, last; nearest valid requester wins.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_rot unassigned (no latch).
    w_rot = r_last;
    for (int k = 4; k >= 1; k--) begin
      if (in_valid[r_last + 2'(k)]) w_rot = r_last + 2'(k);
    end
  end

  assign w_grant = w_hold ? r_last : w_rot;

  // 4:1 payload mux steered by the arbitration decision.
  always_comb begin
    w_sel_data = in_data0;
    unique case (w_grant)
      2'd0: w_sel_data = in_data0;
      2'd1: w_sel_data = in_data1;
      2'd2: w_sel_data = in_data2;
      2'd3: w_sel_data = in_data3;
      default: w_sel_data = in_data0;
    endcase
  end

  // Burst counter advances on a repeat grant, restarts at 1 on a new grantee.
  assign w_run_next = ((w_grant == r_last) && (r_run < MAX_RUN)) ? r_run + 1'b1 : RW'(1);

  // Accept goes only to the grantee, and never while reset is asserted.
  assign in_ready = (w_xfer && rst_n) ? (4'b0001 << w_grant) : 4'b0000;

  // Output register plus arbitration history; idle gaps keep last/run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 2'd0;
      r_last      <= 2'd3;
      r_run       <= '0;
    end else if (w_xfer) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_sel   <= w_grant;
      r_last      <= w_grant;
      r_run       <= w_run_next;
    end else if (w_load) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
